l2_expr_parser: RTL

Upstream command stage for the single-digit adder/subtractor. It consumes a stream of received ASCII bytes (one per `rx_valid` pulse) and parses expressions of the form `digit op digit terminator`. On each valid expression it drives the adder's operand, subtract and start inputs with a one-cycle start pulse. It then holds the operands until the adder's ready pulse returns, or until a timeout expires.

---
 rtl/l2_expr_parser_if.sv | 24 ++
 rtl/l2_expr_parser.sv | 99 +++++++++
 2 files changed

// File: rtl/l2_expr_parser_if.sv
// Byte-stream and adder-side signals for the expression parser.
// master = parser side, slave = the receiver/adder environment.
interface l2_expr_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       L2_adder_rdy;
    logic [7:0] Gl_r1;
    logic [7:0] Gl_r2;
    logic       Gl_subtract;
    logic       Gl_adder_start;
    logic       busy;
    logic       err;
    logic       drop;

    modport master (
        input  rx_data, rx_valid, L2_adder_rdy,
        output Gl_r1, Gl_r2, Gl_subtract, Gl_adder_start, busy, err, drop
    );

    modport slave (
        output rx_data, rx_valid, L2_adder_rdy,
        input  Gl_r1, Gl_r2, Gl_subtract, Gl_adder_start, busy, err, drop
    );
endinterface

// File: rtl/l2_expr_parser.sv
// Parses ASCII "digit op digit terminator" expressions and launches the
// single-digit adder, holding operands until ready or timeout.
module l2_expr_parser #(
    parameter int unsigned RDY_TIMEOUT = 16
) (
    input logic             clk,
    input logic             Gl_rst,
    l2_expr_parser_if.master bus
);
    localparam int CW = $clog2(RDY_TIMEOUT) + 1;
    localparam logic [CW-1:0] TERM = CW'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GOT_R1, GOT_OP, GOT_R2, WAIT_RDY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_digit, is_op, is_term, is_space, take;

    always_comb begin
        is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        is_op    = (bus.rx_data == 8'h2B) || (bus.rx_data == 8'h2D);
        is_term  = (bus.rx_data == 8'h3D) || (bus.rx_data == 8'h0D);
        is_space = (bus.rx_data == 8'h20);
        // Spaces are swallowed while parsing; only real bytes advance the FSM.
        take     = bus.rx_valid && !is_space;
    end

    always_ff @(posedge clk) begin
        if (Gl_rst) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.Gl_r1          <= '0;
            bus.Gl_r2          <= '0;
            bus.Gl_subtract    <= 1'b0;
            bus.Gl_adder_start <= 1'b0;
            bus.busy           <= 1'b0;
            bus.err            <= 1'b0;
            bus.drop           <= 1'b0;
        end else begin
            bus.Gl_adder_start <= 1'b0;
            bus.err            <= 1'b0;
            bus.drop           <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    if (is_digit) begin
                        bus.Gl_r1 <= bus.rx_data;
                        state     <= GOT_R1;
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
                GOT_R1: if (take) begin
                    if (is_op) begin
                        bus.Gl_subtract <= (bus.rx_data == 8'h2D);
                        state           <= GOT_OP;
                    end else begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                GOT_OP: if (take) begin
                    if (is_digit) begin
                        bus.Gl_r2 <= bus.rx_data;
                        state     <= GOT_R2;
                    end else begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                GOT_R2: if (take) begin
                    if (is_term) begin
                        bus.Gl_adder_start <= 1'b1;
                        bus.busy           <= 1'b1;
                        cnt                <= '0;
                        state              <= WAIT_RDY;
                    end else begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WAIT_RDY: begin
                    bus.drop <= bus.rx_valid;
                    // Ready takes priority over the terminal count.
                    if (bus.L2_adder_rdy) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == TERM) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
